instr_dcd_burst: RTL



---
 rtl/instr_dcd_burst_if.sv | 39 +++
 rtl/instr_dcd_burst.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/instr_dcd_burst_if.sv
// ---------------------------------------------------------------------------
// instr_dcd_burst_if
// Bundles the SPI byte-side and register-file-side signals of the
// instruction decoder.
//   frame_active : chip select asserted (SPI side -> decoder)
//   byte_sync    : one-cycle "data_in holds a full byte" pulse
//   data_in      : received MOSI byte
//   data_out     : byte presented for the next MISO transfer
//   read/write   : one-cycle register access strobes
//   addr         : register address, valid with read/write
//   data_read    : register read data, combinationally valid while read=1
//   data_write   : register write data, valid while write=1 (else 0)
//   cmd_err      : one-cycle pulse when a command byte is rejected
// Modports: master = SPI slave + register file side, slave = decoder.
// ---------------------------------------------------------------------------
interface instr_dcd_burst_if #(
    parameter int ADDR_W = 6
) ();
    logic              frame_active;
    logic              byte_sync;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data_read;
    logic [7:0]        data_write;
    logic              cmd_err;

    modport master (
        output frame_active, byte_sync, data_in, data_read,
        input  data_out, read, write, addr, data_write, cmd_err
    );

    modport slave (
        input  frame_active, byte_sync, data_in, data_read,
        output data_out, read, write, addr, data_write, cmd_err
    );
endinterface

// File: rtl/instr_dcd_burst.sv
// ---------------------------------------------------------------------------
// instr_dcd_burst
// SPI instruction decoder: decodes a command byte, then services single or
// auto-incrementing burst register reads/writes, one register byte per SPI
// byte, until chip select is released.
//
// Parameters: ADDR_W (1..6), ADDR_MAX (highest legal address),
//             ERR_BYTE (data_out value after a rejected command).
// Ports:      clk, rst_n (synchronous, active-low), bus (slave modport of
//             instr_dcd_burst_if).
// Build option: define INSTR_DCD_BURST_EN to honour command bit6 (burst);
//               otherwise every command is a single access.
//
// Command byte: [7] 1=write/0=read, [6] burst, [5:ADDR_W] reserved (0),
//               [ADDR_W-1:0] start address.
// ---------------------------------------------------------------------------
module instr_dcd_burst #(
    parameter int         ADDR_W   = 6,
    parameter int         ADDR_MAX = 63,
    parameter logic [7:0] ERR_BYTE = 8'hEE
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_dcd_burst_if.slave bus
);

    typedef enum logic [1:0] {
        CMD  = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

`ifdef INSTR_DCD_BURST_EN
    localparam logic BURST_EN = 1'b1;
`else
    localparam logic BURST_EN = 1'b0;
`endif

    // One extra bit so the range compare never degenerates to a constant.
    localparam logic [ADDR_W:0]   ADDR_MAX_X = ADDR_MAX[ADDR_W:0];
    localparam logic [ADDR_W-1:0] ADDR_MAX_C = ADDR_MAX[ADDR_W-1:0];
    // Bits of the command above the address field that must be zero.
    localparam logic [5:0]        RSVD_MASK  = 6'h3F << ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              burst_q, burst_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              cmd_err_q, cmd_err_d;
    logic [7:0]        data_out_q, data_out_d;
    logic [7:0]        data_write_q, data_write_d;
    logic [ADDR_W-1:0] next_addr_s;
    logic              cmd_bad_s;

`ifdef INSTR_DCD_BURST_EN
    // Burst address advance, wrapping at ADDR_MAX rather than 2^ADDR_W.
    always_comb begin
        if (addr_q == ADDR_MAX_C) begin
            next_addr_s = '0;
        end else begin
            next_addr_s = addr_q + ADDR_W'(1'b1);
        end
    end
`else
    assign next_addr_s = addr_q;
`endif

    assign cmd_bad_s = ({1'b0, bus.data_in[ADDR_W-1:0]} > ADDR_MAX_X) ||
                       ((bus.data_in[5:0] & RSVD_MASK) != 6'd0);

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        burst_d      = burst_q;
        read_d       = 1'b0;
        write_d      = 1'b0;
        cmd_err_d    = 1'b0;
        data_write_d = 8'h00;
        data_out_d   = data_out_q;

        if (!bus.frame_active) begin
            // Frame end wins over everything; a byte_sync here is dropped.
            state_d    = CMD;
            data_out_d = 8'h00;
            burst_d    = 1'b0;
        end else begin
            // Read data is captured in the strobe cycle itself.
            if (read_q) begin
                data_out_d = bus.data_read;
            end else begin
                data_out_d = data_out_q;
            end
            // Burst writes advance the address once the strobe has gone out.
            if (write_q && burst_q) begin
                addr_d = next_addr_s;
            end else begin
                addr_d = addr_q;
            end

            case (state_q)
                CMD: begin
                    if (bus.byte_sync) begin
                        if (cmd_bad_s) begin
                            state_d    = DONE;
                            cmd_err_d  = 1'b1;
                            data_out_d = ERR_BYTE;
                        end else begin
                            addr_d  = bus.data_in[ADDR_W-1:0];
                            burst_d = bus.data_in[6] & BURST_EN;
                            if (bus.data_in[7]) begin
                                state_d = WR;
                            end else begin
                                state_d = RD;
                                read_d  = 1'b1;
                            end
                        end
                    end else begin
                        state_d = CMD;
                    end
                end
                RD: begin
                    // A byte here means the master has shifted out data_out.
                    if (bus.byte_sync) begin
                        if (burst_q) begin
                            addr_d = next_addr_s;
                            read_d = 1'b1;
                        end else begin
                            state_d    = DONE;
                            data_out_d = 8'h00;
                        end
                    end else begin
                        state_d = RD;
                    end
                end
                WR: begin
                    if (bus.byte_sync) begin
                        write_d      = 1'b1;
                        data_write_d = bus.data_in;
                        if (burst_q) begin
                            state_d = WR;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        state_d = WR;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = CMD;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= CMD;
            addr_q       <= '0;
            burst_q      <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            cmd_err_q    <= 1'b0;
            data_out_q   <= 8'h00;
            data_write_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            burst_q      <= burst_d;
            read_q       <= read_d;
            write_q      <= write_d;
            cmd_err_q    <= cmd_err_d;
            data_out_q   <= data_out_d;
            data_write_q <= data_write_d;
        end
    end

    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.addr       = addr_q;
    assign bus.cmd_err    = cmd_err_q;
    assign bus.data_out   = data_out_q;
    assign bus.data_write = data_write_q;

endmodule
